// File: rtl/aes_pkg.sv
// Shared GF(2^8) constants and helpers for the sequential AES S-box engine.
package aes_pkg;

  localparam logic [7:0] GF_POLY    = 8'h1B;
  localparam logic [7:0] GF_GEN     = 8'h03;
  localparam logic [7:0] GF_GEN_INV = 8'hF6;
  localparam logic [7:0] AFF_C      = 8'h63;
  localparam logic [7:0] INVAFF_C   = 8'h05;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} sbox_state_t;

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Shift-and-add multiply by the generator's inverse, MSB first.
  function automatic logic [7:0] gf_mul_f6(input logic [7:0] b);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      acc = xtime(acc);
      if (GF_GEN_INV[i]) acc = acc ^ b;
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ AFF_C;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ INVAFF_C;
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One byte lane: holds the search target, match flag, found inverse and the
// registered substituted output.
module sbox_lane
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       inv_i,
  input  logic       search_i,
  input  logic       cap_i,
  input  logic       mode_i,
  input  logic [7:0] din_i,
  input  logic [7:0] f_i,
  input  logic [7:0] r_i,
  output logic       matched_o,
  output logic [7:0] dout_o
);

  logic [7:0] x_q, x_d, inv_q, inv_d, out_q, out_d;
  logic       m_q, m_d, hit;

  assign hit       = search_i & ~m_q & (f_i == x_q);
  assign matched_o = m_q | hit;
  assign dout_o    = out_q;

  always_comb begin
    x_d   = x_q;
    m_d   = m_q;
    inv_d = inv_q;
    out_d = out_q;
    if (load_i) begin
      x_d   = inv_i ? inv_affine(din_i) : din_i;
      m_d   = (x_d == 8'h00);  // zero has no log; its "inverse" is zero
      inv_d = 8'h00;
    end else if (hit) begin
      m_d   = 1'b1;
      inv_d = r_i;
    end
    // Capture uses inv_d so a match in the exit cycle is included.
    if (cap_i) out_d = mode_i ? inv_d : affine(inv_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      m_q   <= 1'b0;
      inv_q <= '0;
      out_q <= '0;
    end else begin
      x_q   <= x_d;
      m_q   <= m_d;
      inv_q <= inv_d;
      out_q <= out_d;
    end
  end

endmodule

// File: rtl/aes_sbox_seq.sv
// Multi-lane sequential AES S-box (forward/inverse) using a log-walk inverse.
// Define SBOX_FIXED_LATENCY_EN to always search the full field (constant time).
module aes_sbox_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  sbox_state_t state_q, state_d;
  logic [7:0]  f_q, f_d, r_q, r_d, k_q, k_d;
  logic        mode_q, mode_d;
  logic        accept, search, srch_end, cap;
  logic [LANES-1:0]      matched;
  logic [LANES-1:0][7:0] din, dout;

  assign din      = in_data;
  assign out_data = dout;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid & in_ready;
  assign search    = (state_q == SEARCH);

`ifdef SBOX_FIXED_LATENCY_EN
  assign srch_end = (k_q == 8'd254);
`else
  assign srch_end = (k_q == 8'd254) | (&matched);
`endif
  assign cap = search & srch_end;

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    r_d     = r_q;
    k_d     = k_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SEARCH;
        f_d     = 8'h01;
        r_d     = 8'h01;
        k_d     = 8'h00;
        mode_d  = in_inv;
      end
      SEARCH: begin
        f_d = gf_mul3(f_q);
        r_d = gf_mul_f6(r_q);
        k_d = k_q + 8'd1;
        if (srch_end) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      r_q     <= r_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .load_i   (accept),
      .inv_i    (in_inv),
      .search_i (search),
      .cap_i    (cap),
      .mode_i   (mode_q),
      .din_i    (din[i]),
      .f_i      (f_q),
      .r_i      (r_q),
      .matched_o(matched[i]),
      .dout_o   (dout[i])
    );
  end

endmodule

// File: tb/tb_aes_sbox_seq.sv
// Directed bench for aes_sbox_seq (LANES=4): vectors, latency, backpressure,
// reset abort and an exhaustive sweep against the FIPS-197 S-box table.
module tb_aes_sbox_seq;

  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_inv, out_ready;
  logic        in_ready, out_valid, busy;
  logic [31:0] in_data, out_data;

  int checks = 0;
  int errors = 0;

  localparam logic [0:2047] SBOX_TAB = 2048'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;

  logic [0:2047] sb_v;
  logic [7:0]    sbox [256];
  logic [7:0]    isbox[256];

  aes_sbox_seq #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m3(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00) ^ b;
  endfunction

  // Expected accept-to-valid latency from discrete logs base 0x03.
  function automatic int exp_lat(input logic [31:0] d, input logic inv);
    int kmax, k;
    logic [7:0] b, p;
    kmax = 0;
    for (int i = 0; i < 4; i++) begin
      b = d[8*i +: 8];
      if (inv) b = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      if (b != 8'h00) begin
        p = 8'h01; k = 0;
        while (p != b && k < 300) begin p = m3(p); k++; end
        if (k > kmax) kmax = k;
      end
    end
`ifdef SBOX_FIXED_LATENCY_EN
    return 256;
`else
    return kmax + 2;
`endif
  endfunction

  // Issue one request from IDLE, wait (bounded) for out_valid, then accept it.
  task automatic run_txn(input logic inv, input logic [31:0] d,
                         output logic [31:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_inv = inv; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
    res = out_data;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_forward;
    logic [31:0] res; int lat, el;
    el = exp_lat(32'h00010353, 1'b0);
    run_txn(1'b0, 32'h00010353, res, lat);
    checks++; if (res !== 32'h637C7BED) begin errors++; $display("FAIL fwd_vec got %h want 637c7bed", res); end
    checks++; if (lat !== el) begin errors++; $display("FAIL fwd_latency got %0d want %0d", lat, el); end
  endtask

  task automatic test_inverse;
    logic [31:0] res; int lat;
    run_txn(1'b1, 32'h637C7BED, res, lat);
    checks++; if (res !== 32'h00010353) begin errors++; $display("FAIL inv_vec got %h want 00010353", res); end
  endtask

  task automatic test_latency;
    logic [31:0] res; int lat, e1, e2;
`ifdef SBOX_FIXED_LATENCY_EN
    e1 = 256; e2 = 256;
`else
    e1 = 2; e2 = 3;
`endif
    run_txn(1'b0, 32'h01010101, res, lat);
    checks++; if (lat !== e1 || res !== 32'h7C7C7C7C) begin errors++; $display("FAIL lat_all01 got %0d/%h want %0d/7c7c7c7c", lat, res, e1); end
    run_txn(1'b0, 32'h01010301, res, lat);
    checks++; if (lat !== e2 || res !== 32'h7C7C7B7C) begin errors++; $display("FAIL lat_one03 got %0d/%h want %0d/7c7c7b7c", lat, res, e2); end
    run_txn(1'b0, 32'h00000000, res, lat);
    checks++; if (lat !== exp_lat(32'h0, 1'b0) || res !== 32'h63636363) begin errors++; $display("FAIL lat_all00 got %0d/%h", lat, res); end
  endtask

  task automatic test_backpressure;
    logic [31:0] held; int n;
    @(negedge clk); in_valid = 1'b1; in_inv = 1'b0; in_data = 32'h00010353;
    @(posedge clk); #1; in_valid = 1'b0; n = 0;
    while (!out_valid && n < 400) begin @(posedge clk); #1; n++; end
    held = out_data;
    checks++; if (held !== 32'h637C7BED) begin errors++; $display("FAIL bp_data got %h want 637c7bed", held); end
    @(negedge clk); in_valid = 1'b1; in_inv = 1'b1; in_data = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_data !== 32'h637C7BED || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold cyc %0d data %h rdy %b vld %b want 637c7bed 0 1", i, out_data, in_ready, out_valid);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release rdy %b vld %b want 1 0", in_ready, out_valid); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_ignored busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res; int lat;
    @(negedge clk); in_valid = 1'b1; in_inv = 1'b0; in_data = 32'h010101F6;  // 0xF6 = 3^254
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_busy busy %b vld %b want 1 0", busy, out_valid); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset rdy %b vld %b busy %b want 1 0 0", in_ready, out_valid, busy); end
    @(negedge clk); rst = 1'b0;
    run_txn(1'b0, 32'h00010353, res, lat);
    checks++; if (res !== 32'h637C7BED) begin errors++; $display("FAIL mid_after got %h want 637c7bed", res); end
  endtask

  task automatic test_exhaustive;
    logic [31:0] d, e, res; int lat, el;
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < 64; j++) begin
        for (int i = 0; i < 4; i++) begin
          d[8*i +: 8] = (m == 0) ? 8'(4*j+i) : sbox[4*j+i];
          e[8*i +: 8] = (m == 0) ? sbox[4*j+i] : 8'(4*j+i);
        end
        el = exp_lat(d, m[0]);
        run_txn(m[0], d, res, lat);
        checks++;
        if (res !== e || lat !== el) begin
          errors++; $display("FAIL exh mode %0d in %h got %h/%0d want %h/%0d", m, d, res, lat, e, el);
        end
      end
    end
    checks++; if (isbox[8'h63] !== 8'h00 || isbox[8'hED] !== 8'h53) begin errors++; $display("FAIL inv_table %h %h", isbox[8'h63], isbox[8'hED]); end
  endtask

  task automatic test_roundtrip;
    logic [31:0] fw, bk; int lat;
    run_txn(1'b0, 32'hC9A5F610, fw, lat);
    run_txn(1'b1, fw, bk, lat);
    checks++; if (bk !== 32'hC9A5F610) begin errors++; $display("FAIL roundtrip got %h want c9a5f610", bk); end
    checks++; if (fw !== {sbox[8'hC9], sbox[8'hA5], sbox[8'hF6], sbox[8'h10]}) begin errors++; $display("FAIL roundtrip_fwd got %h", fw); end
  endtask

  initial begin
    sb_v = SBOX_TAB;
    for (int i = 0; i < 256; i++) begin
      sbox[i] = sb_v[8*i +: 8];
      isbox[sbox[i]] = 8'(i);
    end
    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset;
    test_forward;
    test_inverse;
    test_latency;
    test_backpressure;
    test_reset_mid;
    test_roundtrip;
    test_exhaustive;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
